// File: rtl/dm_responder_if.sv
// Request/response handshake bundle between a load/store requester and dm_responder.
// Signal names keep the responder's point of view (i_ = into responder, o_ = out of it).
interface dm_responder_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic [DATA_W-1:0] i_req_addr;
  logic [DATA_W-1:0] i_req_wdata;
  logic [BE_W-1:0]   i_req_be;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [DATA_W-1:0] o_rsp_rdata;
  logic              o_rsp_err;

  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_be, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_be, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: one outstanding word-aligned load/store with WAIT_CYC wait states.
// Define DM_BYTE_LANE_EN to make writes honour i_req_be; otherwise every write is full-word.
module dm_responder #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned WAIT_CYC = 2
) (
  input logic           i_clk,
  input logic           i_rst_n,
  dm_responder_if.slave bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
`ifdef DM_BYTE_LANE_EN
  logic [3:0]        be_q, be_d;
`endif
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              accept_c;
  logic              addr_err_c;
  logic              mem_wr_c;
  logic [ADDR_W-1:0] idx_c;

  assign accept_c   = (state == ST_IDLE) && bus.i_req_valid && req_ready_q;
  // Misaligned, or any bit above the word index set: no aliasing onto low memory.
  assign addr_err_c = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_W + 2)) != 32'd0);
  assign idx_c      = addr_q[ADDR_W+1:2];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (accept_c) state_nx = (WAIT_CYC == 0) ? ST_ACCESS : ST_WAIT;
      ST_WAIT:   if (cnt_q == '0) state_nx = ST_ACCESS;
      ST_ACCESS: state_nx = ST_RESP;
      ST_RESP:   if (bus.i_rsp_ready) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs and the latched request.
  always_comb begin
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
`ifdef DM_BYTE_LANE_EN
    be_d        = be_q;
`endif
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_wr_c    = 1'b0;
    req_ready_d = (state_nx == ST_IDLE);
    rsp_valid_d = (state_nx == ST_RESP);
    unique case (state)
      ST_IDLE: begin
        if (accept_c) begin
          we_d    = bus.i_req_we;
          addr_d  = bus.i_req_addr;
          wdata_d = bus.i_req_wdata;
`ifdef DM_BYTE_LANE_EN
          be_d    = bus.i_req_be;
`endif
          cnt_d   = (WAIT_CYC == 0) ? '0 : CNT_W'(WAIT_CYC - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      ST_ACCESS: begin
        rsp_err_d = addr_err_c;
        rdata_d   = (addr_err_c || we_q) ? '0 : mem[idx_c];
        mem_wr_c  = we_q && !addr_err_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
`ifdef DM_BYTE_LANE_EN
      be_q        <= '0;
`endif
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
`ifdef DM_BYTE_LANE_EN
      be_q        <= be_d;
`endif
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
    end
  end

  // Storage is not reset; reset drops state out of ACCESS so a pending write never commits.
  always_ff @(posedge i_clk) begin
    if (mem_wr_c) begin
`ifdef DM_BYTE_LANE_EN
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_c][8*b +: 8] <= wdata_q[8*b +: 8];
      end
`else
      mem[idx_c] <= wdata_q;
`endif
    end
  end

  assign bus.o_req_ready = req_ready_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_rdata = rdata_q;
  assign bus.o_rsp_err   = rsp_err_q;
endmodule
